if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current fetch address, issues one 32-bit instruction read per address over a valid/ready memory request channel, and waits for the response.
- Registers {pc, inst, valid} into the IF/ID pipeline register for decode.
- Drives the PC-hold request back to the PC register and discards in-flight fetches on an ID/EX redirect.

Parameters:
- ADDR_W, 64, fetch address width (matches the PC bus).
- INST_W, 32, instruction width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- pc_i  input  ADDR_W  current PC from the PC register.
- flush_i  input  1  redirect from ID or EX (id_pc_ena | ex_pc_ena); kills the current fetch.
- stall_i  input  1  decode not accepting; hold the IF/ID register.
- mem_req_valid_o  output  1  fetch request valid.
- mem_req_addr_o  output  ADDR_W  fetch address.
- mem_req_ready_i  input  1  memory accepts the request.
- mem_rsp_valid_i  input  1  response valid (in order, at most one outstanding).
- mem_rsp_data_i  input  INST_W  instruction word.
- pc_stall_o  output  1  to PC register/ctrl: hold PC.
- if_pc_o  output  ADDR_W  PC of the registered instruction.
- if_inst_o  output  INST_W  registered instruction.
- if_valid_o  output  1  IF/ID entry valid.
- if_exc_o  output  1  misaligned-fetch flag (only with the optional feature).

Behaviour:
- Reset (async, rst=1):
  - FSM=IDLE, drop=0.
  - All outputs 0, except pc_stall_o=1.
  - Reset mid-operation abandons any outstanding fetch. mem_rsp_valid_i is ignored outside WAIT.
- FSM states:
  - IDLE: transition to REQ on the first clock after reset deasserts.
  - REQ:
    - mem_req_valid_o=1, mem_req_addr_o=pc_i (combinational; PC is held by pc_stall_o, so the address is stable).
    - On handshake (valid & ready): latch req_pc=pc_i, go to WAIT.
    - If flush_i is high in the same cycle as the handshake, set drop=1 (the accepted request carries the stale PC).
    - If flush_i is high without a handshake, stay in REQ; the next cycle uses the redirected pc_i.
  - WAIT:
    - On mem_rsp_valid_i with drop=1 or flush_i=1: discard the data, clear drop, go to REQ.
    - On mem_rsp_valid_i, no drop, stall_i=0: load IF/ID with {req_pc, data, 1}, go to REQ.
    - On mem_rsp_valid_i, no drop, stall_i=1: capture into hold buffer, go to HOLD.
    - flush_i without a response: set drop=1, stay in WAIT.
  - HOLD:
    - stall_i=0 and flush_i=0: move the buffer to IF/ID, go to REQ.
    - flush_i=1: discard the buffer, go to REQ.
- pc_stall_o:
  - Low only in the transfer cycle (WAIT delivery or HOLD release into IF/ID). The PC advances to its predicted value on that edge.
  - High in every other cycle. A flush still updates the PC because the PC register gives redirects priority.
- IF/ID register:
  - flush_i=1: if_valid_o<=0 (pc/inst don't-care, hold).
  - Else if stall_i=1: hold all fields.
  - Else if transfer: load the new entry.
  - Else: if_valid_o<=0 (bubble).
- Timing:
  - Latency with a zero-wait memory (ready=1, rsp the cycle after the handshake): REQ -> WAIT -> if_valid_o the following cycle.
  - Steady throughput: 1 instruction per 2 cycles.
- At most one outstanding request. mem_req_valid_o is 0 in IDLE, WAIT and HOLD.

Optional Feature:
- Macro: IF_MISALIGN_EXC_EN.
- Enabled:
  - In REQ, pc_i[1:0]!=0 issues no memory request.
  - On the next cycle, if_valid_o=1, if_exc_o=1, if_inst_o=0x00000013 (NOP), if_pc_o=pc_i, with pc_stall_o low for that transfer cycle.
  - Stall and flush rules are identical to a normal transfer.
- Disabled: if_exc_o is tied to 0, the address is issued unchanged, and no extra logic is generated.

Test Plan:
- Reset, pc_i=0x80000000, ready=1, rsp one cycle after the handshake with 0x00000093 -> if_valid_o=1, if_pc_o=0x80000000, if_inst_o=0x00000093 on the 3rd cycle after reset release; pc_stall_o low exactly one cycle before that.
- Three back-to-back fetches 0x80000000/04/08 -> if_valid_o pulses every 2nd cycle; no request is issued while in WAIT.
- flush_i in WAIT, pc_i redirected to 0x80001000, stale rsp 0xDEADBEEF arrives -> the response is dropped, the next request address is 0x80001000, and if_valid_o never shows 0xDEADBEEF.
- stall_i=1 for 4 cycles when rsp 0x00100073 arrives -> FSM in HOLD, IF/ID unchanged, pc_stall_o=1; on release the entry loads next cycle with the correct PC.
- ready=0 for 5 cycles -> mem_req_valid_o and mem_req_addr_o remain stable; async rst asserted in WAIT clears if_valid_o immediately and restarts at IDLE.
- With IF_MISALIGN_EXC_EN, pc_i=0x80000002 -> no mem_req_valid_o, if_exc_o=1, if_inst_o=0x00000013.

Source files
------------

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage with IF/ID register; optional misaligned-fetch exception under IF_MISALIGN_EXC_EN
module if_fetch #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              flush_i,
   input  logic              stall_i,
   output logic              mem_req_valid_o,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   input  logic              mem_req_ready_i,
   input  logic              mem_rsp_valid_i,
   input  logic [INST_W-1:0] mem_rsp_data_i,
   output logic              pc_stall_o,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [INST_W-1:0] if_inst_o,
   output logic              if_valid_o,
   output logic              if_exc_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam logic [INST_W-1:0] NOP_INST = INST_W'('h13);

   logic [1:0]        state;
   logic              drop;
   logic [ADDR_W-1:0] req_pc;
   logic [ADDR_W-1:0] hold_pc;
   logic [INST_W-1:0] hold_inst;

   logic              misalign;
   logic              xfer;
   logic [ADDR_W-1:0] xfer_pc;
   logic [INST_W-1:0] xfer_inst;

`ifdef IF_MISALIGN_EXC_EN
   logic hold_exc;
   logic xfer_exc;
   assign misalign = (state == S_REQ) && (pc_i[1:0] != 2'b00);
   assign xfer_exc = (state == S_HOLD) ? hold_exc : misalign;
`else
   assign misalign = 1'b0;
`endif

   // A misaligned PC never reaches memory; the address bus is quiet whenever no request is offered
   assign mem_req_valid_o = (state == S_REQ) && !misalign;
   assign mem_req_addr_o  = mem_req_valid_o ? pc_i : '0;
   assign pc_stall_o      = !xfer;

   // Select the entry moving into IF/ID this cycle, if any
   always_comb begin
      xfer      = 1'b0;
      xfer_pc   = req_pc;
      xfer_inst = mem_rsp_data_i;
      case (state)
         S_WAIT: xfer = mem_rsp_valid_i && !drop && !flush_i && !stall_i;
         S_HOLD: begin
            xfer      = !stall_i && !flush_i;
            xfer_pc   = hold_pc;
            xfer_inst = hold_inst;
         end
         S_REQ: begin
            if (misalign) begin
               xfer      = !stall_i && !flush_i;
               xfer_pc   = pc_i;
               xfer_inst = NOP_INST;
            end
         end
         default: xfer = 1'b0;
      endcase
   end

   // Fetch FSM: one outstanding request, stale responses discarded via drop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         drop      <= 1'b0;
         req_pc    <= '0;
         hold_pc   <= '0;
         hold_inst <= '0;
      end else begin
         case (state)
            S_IDLE: state <= S_REQ;
            S_REQ: begin
               if (misalign) begin
                  if (!flush_i && stall_i) begin
                     hold_pc   <= pc_i;
                     hold_inst <= NOP_INST;
                     state     <= S_HOLD;
                  end
               end else if (mem_req_ready_i) begin
                  req_pc <= pc_i;
                  drop   <= flush_i;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_rsp_valid_i) begin
                  drop <= 1'b0;
                  if (drop || flush_i) begin
                     state <= S_REQ;
                  end else if (stall_i) begin
                     hold_pc   <= req_pc;
                     hold_inst <= mem_rsp_data_i;
                     state     <= S_HOLD;
                  end else begin
                     state <= S_REQ;
                  end
               end else if (flush_i) begin
                  drop <= 1'b1;
               end
            end
            S_HOLD: begin
               if (flush_i || !stall_i) state <= S_REQ;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // IF/ID pipeline register: flush kills, stall holds, otherwise load or bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid_o <= 1'b0;
         if_pc_o    <= '0;
         if_inst_o  <= '0;
      end else if (flush_i) begin
         if_valid_o <= 1'b0;
      end else if (!stall_i) begin
         if_valid_o <= xfer;
         if (xfer) begin
            if_pc_o   <= xfer_pc;
            if_inst_o <= xfer_inst;
         end
      end
   end

`ifdef IF_MISALIGN_EXC_EN
   // Exception flag travels with the held entry and with the IF/ID valid bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_exc <= 1'b0;
         if_exc_o <= 1'b0;
      end else begin
         if (state == S_REQ && misalign && !flush_i && stall_i) hold_exc <= 1'b1;
         else if (state == S_WAIT && mem_rsp_valid_i) hold_exc <= 1'b0;
         if (flush_i) if_exc_o <= 1'b0;
         else if (!stall_i) if_exc_o <= xfer && xfer_exc;
      end
   end
`else
   assign if_exc_o = 1'b0;
`endif

endmodule
